// File: rtl/ddr_amm_pkg.sv
// Shared widths, FSM state encoding and burst helper for the DDR Avalon-MM responder.
package ddr_amm_pkg;

    localparam int AMM_AW  = 25;
    localparam int AMM_DW  = 256;
    localparam int AMM_BEW = 32;
    localparam int AMM_BCW = 7;

    typedef enum logic [1:0] {
        CAL,
        IDLE,
        WR_BURST,
        RD_BURST
    } amm_state_e;

    // Index of the final beat; a burstcount of zero behaves as a single beat.
    function automatic logic [AMM_BCW-1:0] last_beat(input logic [AMM_BCW-1:0] bc);
        return (bc == '0) ? '0 : bc - AMM_BCW'(1);
    endfunction

endpackage

// File: rtl/ddr_amm_resp_ram.sv
// Byte-enabled simple dual-port RAM with a registered read port and
// write-to-read bypass, so a same-cycle write to the read word is returned.
module ddr_amm_resp_ram #(
    parameter int AW  = 6,
    parameter int DW  = 256,
    parameter int BEW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [BEW-1:0] wr_be,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_word;
    logic [DW-1:0] rd_data_q;

    // NOTE: the storage array has no reset; clearing it would turn block RAM into flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BEW; b++) begin
                if (wr_be[b]) mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem_q[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            for (int b = 0; b < BEW; b++) begin
                if (wr_be[b]) rd_word[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    // Output register only loads on a read, so read data holds between bursts.
    always_ff @(posedge clk) begin
        if (rst)        rd_data_q <= '0;
        else if (rd_en) rd_data_q <= rd_word;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ddr_amm_responder.sv
// Avalon-MM DDR controller emulation: calibration delay, burst reads/writes to
// an internal RAM. Optional random backpressure via DDR_AMM_RESP_BACKPRESSURE_EN.
module ddr_amm_responder
    import ddr_amm_pkg::*;
#(
    parameter int MEM_AW     = 6,
    parameter int CAL_CYCLES = 64
) (
    input  logic               avalon_clk,
    input  logic               avalon_reset,
    input  logic [AMM_AW-1:0]  amm_addr,
    input  logic [AMM_DW-1:0]  amm_writedata,
    input  logic [AMM_BEW-1:0] amm_byteenable,
    input  logic               amm_read,
    input  logic               amm_write,
    input  logic [AMM_BCW-1:0] amm_burstcount,
    output logic               amm_ready,
    output logic [AMM_DW-1:0]  amm_readdata,
    output logic               amm_readdatavalid,
    output logic               local_cal_success,
    output logic               local_cal_fail
);

    localparam int CAL_CW = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES) : 1;

    amm_state_e         state_q, state_d;
    logic [CAL_CW-1:0]  cal_cnt_q, cal_cnt_d;
    logic               cal_ok_q, cal_ok_d;
    logic [MEM_AW-1:0]  base_q, base_d;
    logic [AMM_BCW-1:0] last_q, last_d;
    logic [AMM_BCW-1:0] beat_q, beat_d;
    logic               rvalid_q;

    logic               stall;
    logic [MEM_AW-1:0]  burst_addr;
    logic               ram_we, ram_re;
    logic [MEM_AW-1:0]  ram_waddr;
    logic               addr_unused;

    assign addr_unused = ^amm_addr[AMM_AW-1:MEM_AW];
    assign burst_addr  = base_q + MEM_AW'(beat_q);

`ifdef DDR_AMM_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge avalon_clk) begin
        if (avalon_reset) lfsr_q <= 16'hACE1;
        else              lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cal_cnt_d = cal_cnt_q;
        cal_ok_d  = cal_ok_q;
        base_d    = base_q;
        last_d    = last_q;
        beat_d    = beat_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = burst_addr;
        amm_ready = 1'b0;

        unique case (state_q)
            CAL: begin
                if (cal_cnt_q == CAL_CW'(CAL_CYCLES - 1)) begin
                    cal_ok_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cal_cnt_d = cal_cnt_q + CAL_CW'(1);
                end
            end
            IDLE: begin
                // Hold off new commands while the final read beat is on the bus.
                amm_ready = !rvalid_q && !stall;
                if (amm_ready && amm_write) begin
                    ram_we    = 1'b1;
                    ram_waddr = amm_addr[MEM_AW-1:0];
                    base_d    = amm_addr[MEM_AW-1:0];
                    last_d    = last_beat(amm_burstcount);
                    beat_d    = AMM_BCW'(1);
                    if (last_beat(amm_burstcount) != '0) state_d = WR_BURST;
                end else if (amm_ready && amm_read) begin
                    base_d  = amm_addr[MEM_AW-1:0];
                    last_d  = last_beat(amm_burstcount);
                    beat_d  = '0;
                    state_d = RD_BURST;
                end
            end
            WR_BURST: begin
                amm_ready = !stall;
                if (amm_ready && amm_write) begin
                    ram_we = 1'b1;
                    beat_d = beat_q + AMM_BCW'(1);
                    if (beat_q == last_q) state_d = IDLE;
                end
            end
            RD_BURST: begin
                ram_re = 1'b1;
                beat_d = beat_q + AMM_BCW'(1);
                if (beat_q == last_q) state_d = IDLE;
            end
            default: state_d = CAL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge avalon_clk) begin
        if (avalon_reset) begin
            state_q   <= CAL;
            cal_cnt_q <= '0;
            cal_ok_q  <= 1'b0;
            base_q    <= '0;
            last_q    <= '0;
            beat_q    <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cal_cnt_q <= cal_cnt_d;
            cal_ok_q  <= cal_ok_d;
            base_q    <= base_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            rvalid_q  <= ram_re;
        end
    end

    ddr_amm_resp_ram #(
        .AW  (MEM_AW),
        .DW  (AMM_DW),
        .BEW (AMM_BEW)
    ) u_ram (
        .clk     (avalon_clk),
        .rst     (avalon_reset),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (amm_writedata),
        .wr_be   (amm_byteenable),
        .rd_en   (ram_re),
        .rd_addr (burst_addr),
        .rd_data (amm_readdata)
    );

    assign amm_readdatavalid = rvalid_q;
    assign local_cal_success = cal_ok_q;
    assign local_cal_fail    = 1'b0;

endmodule

// File: tb/tb_ddr_amm_responder.sv
// Directed bench for ddr_amm_responder: calibration, bursts, byte enables,
// address wrap, read/write collision, readdata hold and mid-burst reset.
module tb_ddr_amm_responder;

    logic         avalon_clk;
    logic         avalon_reset;
    logic [24:0]  amm_addr;
    logic [255:0] amm_writedata;
    logic [31:0]  amm_byteenable;
    logic         amm_read;
    logic         amm_write;
    logic [6:0]   amm_burstcount;
    logic         amm_ready;
    logic [255:0] amm_readdata;
    logic         amm_readdatavalid;
    logic         local_cal_success;
    logic         local_cal_fail;

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] wr_beats [8];
    logic [255:0] rd_beats [8];
    int           rd_n, rd_first, rd_last;
    logic         rd_ready_last, rd_ready_after;

    ddr_amm_responder #(.MEM_AW(6), .CAL_CYCLES(64)) dut (
        .avalon_clk        (avalon_clk),
        .avalon_reset      (avalon_reset),
        .amm_addr          (amm_addr),
        .amm_writedata     (amm_writedata),
        .amm_byteenable    (amm_byteenable),
        .amm_read          (amm_read),
        .amm_write         (amm_write),
        .amm_burstcount    (amm_burstcount),
        .amm_ready         (amm_ready),
        .amm_readdata      (amm_readdata),
        .amm_readdatavalid (amm_readdatavalid),
        .local_cal_success (local_cal_success),
        .local_cal_fail    (local_cal_fail)
    );

    initial avalon_clk = 1'b0;
    always #5 avalon_clk = ~avalon_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_write(input logic [24:0] addr, input logic [6:0] bc, input logic [31:0] be);
        int nb;
        int w;
        nb = (bc == 7'd0) ? 1 : int'(bc);
        for (int i = 0; i < nb; i++) begin
            amm_write      = 1'b1;
            amm_addr       = (i == 0) ? addr : 25'h1FF_FFFF;
            amm_writedata  = wr_beats[i];
            amm_byteenable = be;
            amm_burstcount = bc;
            w = 0;
            while (!amm_ready && w < 50) begin
                @(negedge avalon_clk);
                w++;
            end
            if (!amm_ready) begin
                n_tests++;
                n_fail++;
                $display("FAIL write_accept: ready=%0b after %0d cycles, required 1", amm_ready, w);
                amm_write = 1'b0;
                return;
            end
            @(negedge avalon_clk);
        end
        amm_write = 1'b0;
    endtask

    task automatic do_read(input logic [24:0] addr, input logic [6:0] bc);
        int w;
        int nb;
        nb = (bc == 7'd0) ? 1 : int'(bc);
        rd_n = 0; rd_first = -1; rd_last = -1;
        rd_ready_last = 1'bx; rd_ready_after = 1'bx;
        amm_read       = 1'b1;
        amm_addr       = addr;
        amm_burstcount = bc;
        w = 0;
        while (!amm_ready && w < 50) begin
            @(negedge avalon_clk);
            w++;
        end
        if (!amm_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL read_accept: ready=%0b after %0d cycles, required 1", amm_ready, w);
            amm_read = 1'b0;
            return;
        end
        for (int c = 1; c <= nb + 4; c++) begin
            @(negedge avalon_clk);
            if (amm_readdatavalid) begin
                if (rd_n < 8) rd_beats[rd_n] = amm_readdata;
                rd_n++;
                if (rd_first < 0) rd_first = c;
                rd_last = c;
                rd_ready_last = amm_ready;
            end else if (rd_last > 0 && c == rd_last + 1) begin
                rd_ready_after = amm_ready;
            end
            if (c == 1) amm_read = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic any_ready;
        avalon_reset = 1'b1;
        repeat (3) @(negedge avalon_clk);
        n_tests++;
        if (amm_ready !== 1'b0 || amm_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: ready=%0b rdv=%0b, required 0 0", amm_ready, amm_readdatavalid);
        end
        n_tests++;
        if (amm_readdata !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_readdata: got %h, required 0", amm_readdata);
        end
        n_tests++;
        if (local_cal_success !== 1'b0 || local_cal_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cal: success=%0b fail=%0b, required 0 0", local_cal_success, local_cal_fail);
        end
        avalon_reset = 1'b0;
        any_ready = 1'b0;
        for (int i = 0; i < 63; i++) begin
            @(negedge avalon_clk);
            if (amm_ready !== 1'b0) any_ready = 1'b1;
        end
        n_tests++;
        if (local_cal_success !== 1'b0 || any_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cal_early: success=%0b ready_seen=%0b at 63 cycles, required 0 0",
                     local_cal_success, any_ready);
        end
        @(negedge avalon_clk);
        n_tests++;
        if (local_cal_success !== 1'b1 || amm_ready !== 1'b1 || local_cal_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL cal_done: success=%0b ready=%0b fail=%0b at 64 cycles, required 1 1 0",
                     local_cal_success, amm_ready, local_cal_fail);
        end
    endtask

    task automatic test_write_read_burst();
        for (int i = 0; i < 4; i++) wr_beats[i] = {8{32'hC0DE_0000 + 32'(i)}} ^ {32{8'(i * 17)}};
        do_write(25'h10, 7'd4, 32'hFFFF_FFFF);
        do_read(25'h10, 7'd4);
        n_tests++;
        if (rd_first !== 2 || rd_last !== 5 || rd_n !== 4) begin
            n_fail++;
            $display("FAIL burst_timing: first=%0d last=%0d beats=%0d, required 2 5 4", rd_first, rd_last, rd_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rd_beats[i] !== wr_beats[i]) begin
                n_fail++;
                $display("FAIL burst_data[%0d]: got %h, required %h", i, rd_beats[i], wr_beats[i]);
            end
        end
        n_tests++;
        if (rd_ready_last !== 1'b0 || rd_ready_after !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_ready: at_last=%0b after_last=%0b, required 0 1", rd_ready_last, rd_ready_after);
        end
    endtask

    task automatic test_byteenable();
        logic [255:0] exp;
        exp = {{224{1'b1}}, 32'h0};
        wr_beats[0] = '1;
        do_write(25'd5, 7'd1, 32'hFFFF_FFFF);
        wr_beats[0] = '0;
        do_write(25'd5, 7'd1, 32'h0000_000F);
        do_read(25'd5, 7'd1);
        n_tests++;
        if (rd_n !== 1 || rd_beats[0] !== exp) begin
            n_fail++;
            $display("FAIL byteenable: beats=%0d data=%h, required 1 %h", rd_n, rd_beats[0], exp);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) wr_beats[i] = {64{4'hE}} - 256'(i);
        do_write(25'd62, 7'd3, 32'hFFFF_FFFF);
        do_read(25'd0, 7'd1);
        n_tests++;
        if (rd_n !== 1 || rd_beats[0] !== wr_beats[2]) begin
            n_fail++;
            $display("FAIL wrap_word0: beats=%0d data=%h, required 1 %h", rd_n, rd_beats[0], wr_beats[2]);
        end
        do_read(25'd63, 7'd2);
        n_tests++;
        if (rd_n !== 2 || rd_beats[0] !== wr_beats[1] || rd_beats[1] !== wr_beats[2]) begin
            n_fail++;
            $display("FAIL wrap_read: beats=%0d data0=%h data1=%h, required 2 %h %h",
                     rd_n, rd_beats[0], rd_beats[1], wr_beats[1], wr_beats[2]);
        end
        do_read(25'd126, 7'd1);
        n_tests++;
        if (rd_beats[0] !== wr_beats[0]) begin
            n_fail++;
            $display("FAIL addr_modulo: got %h, required %h", rd_beats[0], wr_beats[0]);
        end
    endtask

    task automatic test_collision();
        logic [255:0] exp;
        exp = {16{16'hF00D}};
        amm_addr       = 25'h20;
        amm_burstcount = 7'd1;
        amm_writedata  = exp;
        amm_byteenable = 32'hFFFF_FFFF;
        amm_write      = 1'b1;
        amm_read       = 1'b1;
        n_tests++;
        if (amm_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_ready: got %0b, required 1", amm_ready);
        end
        @(negedge avalon_clk);
        amm_write = 1'b0;
        n_tests++;
        if (amm_ready !== 1'b1 || amm_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_read_pending: ready=%0b rdv=%0b, required 1 0", amm_ready, amm_readdatavalid);
        end
        @(negedge avalon_clk);
        amm_read = 1'b0;
        n_tests++;
        if (amm_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_latency: rdv=%0b one cycle after accept, required 0", amm_readdatavalid);
        end
        @(negedge avalon_clk);
        n_tests++;
        if (amm_readdatavalid !== 1'b1 || amm_readdata !== exp) begin
            n_fail++;
            $display("FAIL collision_data: rdv=%0b data=%h, required 1 %h", amm_readdatavalid, amm_readdata, exp);
        end
        repeat (2) @(negedge avalon_clk);
    endtask

    task automatic test_bc_zero_and_hold();
        wr_beats[0] = {32{8'h5A}};
        do_write(25'h30, 7'd0, 32'hFFFF_FFFF);
        do_read(25'h30, 7'd0);
        n_tests++;
        if (rd_n !== 1 || rd_first !== 2 || rd_beats[0] !== wr_beats[0]) begin
            n_fail++;
            $display("FAIL bc_zero: beats=%0d first=%0d data=%h, required 1 2 %h",
                     rd_n, rd_first, rd_beats[0], wr_beats[0]);
        end
        repeat (3) @(negedge avalon_clk);
        n_tests++;
        if (amm_readdatavalid !== 1'b0 || amm_readdata !== wr_beats[0]) begin
            n_fail++;
            $display("FAIL readdata_hold: rdv=%0b data=%h, required 0 %h", amm_readdatavalid, amm_readdata, wr_beats[0]);
        end
    endtask

    task automatic test_reset_midburst();
        logic saw_valid;
        amm_addr       = 25'h10;
        amm_burstcount = 7'd4;
        amm_read       = 1'b1;
        @(negedge avalon_clk);
        amm_read = 1'b0;
        @(negedge avalon_clk);
        avalon_reset = 1'b1;
        @(negedge avalon_clk);
        n_tests++;
        if (amm_readdatavalid !== 1'b0 || amm_readdata !== 256'd0 || amm_ready !== 1'b0 ||
            local_cal_success !== 1'b0) begin
            n_fail++;
            $display("FAIL midburst_reset: rdv=%0b data=%h ready=%0b cal=%0b, required 0 0 0 0",
                     amm_readdatavalid, amm_readdata, amm_ready, local_cal_success);
        end
        avalon_reset = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge avalon_clk);
            if (amm_readdatavalid !== 1'b0) saw_valid = 1'b1;
        end
        n_tests++;
        if (saw_valid !== 1'b0 || local_cal_success !== 1'b1 || amm_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midburst_abort: rdv_seen=%0b cal=%0b ready=%0b, required 0 1 1",
                     saw_valid, local_cal_success, amm_ready);
        end
    endtask

    initial begin
        avalon_reset   = 1'b1;
        amm_addr       = '0;
        amm_writedata  = '0;
        amm_byteenable = '0;
        amm_read       = 1'b0;
        amm_write      = 1'b0;
        amm_burstcount = '0;
        @(negedge avalon_clk);
        test_reset();
        test_write_read_burst();
        test_byteenable();
        test_wrap();
        test_collision();
        test_bc_zero_and_hold();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_amm_responder.md
DDR_AMM_RESPONDER -- requirements
Module: ddr_amm_responder

Interface
REQ-001 The module SHALL have parameter MEM_AW, default 6, meaning log2 of the backing-store depth in 256-bit words.
REQ-002 The module SHALL have parameter CAL_CYCLES, default 64, meaning cycles from reset release to calibration-complete.
REQ-003 The module SHALL have port avalon_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port avalon_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port amm_addr, input, 25 bits: word address, sampled on the first beat of a command.
REQ-006 The module SHALL have port amm_writedata, input, 256 bits: write data.
REQ-007 The module SHALL have port amm_byteenable, input, 32 bits: per-byte write enable.
REQ-008 The module SHALL have ports amm_read and amm_write, input, 1 bit each: command strobes.
REQ-009 The module SHALL have port amm_burstcount, input, 7 bits: beats per command.
REQ-010 The module SHALL have port amm_ready, output, 1 bit: high means the current beat or command is accepted this cycle.
REQ-011 The module SHALL have port amm_readdata, output, 256 bits: read data.
REQ-012 The module SHALL have port amm_readdatavalid, output, 1 bit: qualifies amm_readdata.
REQ-013 The module SHALL have ports local_cal_success and local_cal_fail, output, 1 bit each: emulated calibration status.

Function
REQ-014 FSM states SHALL be CAL, IDLE, WR_BURST and RD_BURST; CAL SHALL be entered on reset.
REQ-015 CAL: an internal counter SHALL count CAL_CYCLES; on expiry, local_cal_success SHALL go to 1 (sticky until reset) and the FSM SHALL go to IDLE; amm_ready SHALL be 0 throughout CAL.
REQ-016 IDLE: amm_ready SHALL be 1; amm_write accepted -> beat 0 written, latch addr/burstcount, go to WR_BURST (or stay in IDLE if burstcount is 1).
REQ-017 IDLE: amm_read accepted -> latch addr/burstcount, go to RD_BURST.
REQ-018 If amm_read and amm_write are both high in IDLE, the write SHALL win and the read SHALL stay pending, not accepted.
REQ-019 Burstcount 0 SHALL be treated as 1.
REQ-020 WR_BURST: each amm_write beat with amm_ready high SHALL write to address base+beat; amm_addr on these beats SHALL be ignored.
REQ-021 WR_BURST: after the last beat the FSM SHALL return to IDLE; amm_read in WR_BURST SHALL be ignored.
REQ-022 Writes SHALL update only the bytes whose amm_byteenable bit is 1.
REQ-023 RD_BURST: amm_ready SHALL be 0.
REQ-024 RD_BURST: beat k SHALL appear with amm_readdatavalid=1 in cycle T+2+k, where T is the accept cycle, with no gaps.
REQ-025 RD_BURST: after the last beat is issued, the FSM SHALL go to IDLE and amm_ready SHALL be 1 in the cycle after the final readdatavalid.
REQ-026 Memory index SHALL be (address) modulo 2^MEM_AW; the burst address SHALL wrap from 2^MEM_AW-1 to 0.
REQ-027 A read of a word written in the cycle immediately before the read accept SHALL return the new data.
REQ-028 amm_readdata SHALL hold its last value when amm_readdatavalid is 0.

Reset
REQ-029 During avalon_reset high: amm_ready=0, amm_readdatavalid=0, amm_readdata=0, local_cal_success=0, local_cal_fail=0, FSM=CAL, counters cleared.
REQ-030 Reset mid-burst SHALL abort the burst; no further readdatavalid SHALL occur; memory contents SHALL be unspecified.

Configuration
REQ-031 Macro DDR_AMM_RESP_BACKPRESSURE_EN: when defined, a 16-bit LFSR (seed 16'hACE1, reset-loaded) SHALL force amm_ready=0 in IDLE/WR_BURST whenever LFSR[1:0]==2'b00; the LFSR SHALL advance every cycle.
REQ-032 When DDR_AMM_RESP_BACKPRESSURE_EN is not defined, amm_ready SHALL follow REQ-015..REQ-025 exactly.
REQ-033 Read-data timing SHALL be unaffected by DDR_AMM_RESP_BACKPRESSURE_EN.

Structure
REQ-034 Package ddr_amm_pkg SHALL hold AMM_AW=25, AMM_DW=256, AMM_BEW=32, AMM_BCW=7 and the FSM state enum.
REQ-035 Sub-module ddr_amm_resp_ram SHALL implement the byte-enabled simple dual-port RAM with 1-cycle registered read.
REQ-036 Sub-module ddr_amm_resp_ram SHALL implement the write-to-read bypass required by REQ-027.

Verification
REQ-037 Reset release, CAL_CYCLES=64 -> local_cal_success rises exactly 64 cycles later; amm_ready=0 until then.
REQ-038 Write burst addr=0x10, bc=4, data D0..D3, byteenable all-ones; then read addr=0x10, bc=4 -> readdatavalid at T+2..T+5 returning D0..D3.
REQ-039 Write addr=5 with byteenable=0x0000000F over a word previously all-ones, data 0 -> read returns low 4 bytes 0, rest 0xFF.
REQ-040 MEM_AW=6, write bc=3 at addr 62 -> data lands at words 62, 63, 0; read addr 0 returns the third beat.
REQ-041 Simultaneous amm_read and amm_write in IDLE -> write accepted first; read accepted on a later cycle.
REQ-042 With DDR_AMM_RESP_BACKPRESSURE_EN defined, random-traffic scoreboard run -> zero data mismatches; amm_ready low observed at least once per 16 cycles on average.
